// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end: default element sizes used by
// both the window generator and the MAC stage, the window-generator state
// encoding, and the window element index helpers.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_IN_CHANNEL  = 3;

  // Elements per channel in one window for the default kernel size.
  localparam int WIN_ELEMS = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

  // FILL: still buffering the first K-1 rows. STREAM: windows may be emitted.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_e;

  // Flat element index of (ch, r, c) inside a packed window of side k.
  function automatic int win_index(input int ch, input int r, input int c, input int k);
    return ch * k * k + r * k + c;
  endfunction

endpackage

// File: rtl/mc_line_buffer.sv
// Single-channel line buffer holding the previous KERNEL_SIZE-1 rows.
// The column addressed by col is read combinationally (zero latency), and on
// a write the column shifts up by one row with the new pixel entering at the
// bottom. Contents are deliberately not reset; every location is rewritten
// during the fill rows before it is ever read into an emitted window.
module mc_line_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int COL_W       = $clog2(IMG_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [COL_W-1:0]                      col,
  input  logic [DATA_WIDTH-1:0]                 pixel,
  output logic [(KERNEL_SIZE-1)*DATA_WIDTH-1:0] column
);

  // mem[0] is the oldest buffered row, mem[KERNEL_SIZE-2] the most recent.
  logic [DATA_WIDTH-1:0] mem [KERNEL_SIZE-1][IMG_WIDTH];

  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_rd
    assign column[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][col];
  end

  // Shift the addressed column up one row and store the incoming pixel.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < KERNEL_SIZE - 2; k++) begin
        mem[k][col] <= mem[k+1][col];
      end
      mem[KERNEL_SIZE-2][col] <= pixel;
    end
  end

endmodule

// File: rtl/mc_window_gen.sv
// Streaming multi-channel sliding-window generator (stride 1, no padding).
// Accepts one C-channel pixel per cycle in raster order and emits a packed
// K x K x C window for every valid output position, element (ch,r,c) at
// [(ch*K*K + r*K + c)*DATA_WIDTH +: DATA_WIDTH], r=0 top row, c=0 left column.
//
// Handshakes: a pixel transfers when pixel_valid && pixel_ready; a window
// transfers when window_valid && window_ready. window_out is held stable while
// window_valid && !window_ready, and no pixel is taken in that state.
//
// Optional build macro MC_WINDOW_GEN_COUNT_EN adds the win_count output,
// counting window transfers and clearing on rst and on the frame_done cycle.
module mc_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IN_CHANNEL  = DEF_IN_CHANNEL,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    pixel_valid,
  output logic                                                    pixel_ready,
  input  logic [IN_CHANNEL*DATA_WIDTH-1:0]                        pixel_in,
  output logic                                                    window_valid,
  input  logic                                                    window_ready,
  output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
`ifdef MC_WINDOW_GEN_COUNT_EN
  output logic [$clog2((IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1)+1)-1:0] win_count,
`endif
  output logic                                                    frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int WIN_W = IN_CHANNEL * KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(KERNEL_SIZE - 2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  win_state_e       state;

  logic             accept;
  logic             emit;
  logic             col_last;
  logic             row_last;

  logic [WIN_W-1:0] shift_win;
  logic [WIN_W-1:0] next_win;
  logic [(KERNEL_SIZE-1)*DATA_WIDTH-1:0] lb_col [IN_CHANNEL];

  assign pixel_ready = !window_valid || window_ready;
  assign accept      = pixel_valid && pixel_ready;
  assign col_last    = (col == COL_LAST);
  assign row_last    = (row == ROW_LAST);
  // A window needs K-1 full rows above and K-1 columns to the left in this row,
  // so positions that would straddle a row wrap never emit.
  assign emit        = accept && (state == STREAM) && (col >= COL_FIRST);

  // Raster position counters, FILL/STREAM state and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      state      <= FILL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row   <= '0;
            state <= FILL;
          end else begin
            row <= row + ROW_W'(1);
            if (row == ROW_FILL) state <= STREAM;
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  for (genvar ch = 0; ch < IN_CHANNEL; ch++) begin : g_lb
    mc_line_buffer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .KERNEL_SIZE (KERNEL_SIZE),
      .IMG_WIDTH   (IMG_WIDTH),
      .COL_W       (COL_W)
    ) u_lb (
      .clk    (clk),
      .wr_en  (accept),
      .col    (col),
      .pixel  (pixel_in[ch*DATA_WIDTH +: DATA_WIDTH]),
      .column (lb_col[ch])
    );
  end

  // Next window: every column moves one place left; the new right-hand column
  // is the buffered rows of the current column topped off by the live pixel.
  for (genvar ch = 0; ch < IN_CHANNEL; ch++) begin : g_ch
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_r
      for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_c
        localparam int IDX = win_index(ch, r, c, KERNEL_SIZE) * DATA_WIDTH;
        if (c < KERNEL_SIZE - 1) begin : g_shift
          assign next_win[IDX +: DATA_WIDTH] = shift_win[IDX + DATA_WIDTH +: DATA_WIDTH];
        end else if (r < KERNEL_SIZE - 1) begin : g_buf
          assign next_win[IDX +: DATA_WIDTH] = lb_col[ch][r*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_live
          assign next_win[IDX +: DATA_WIDTH] = pixel_in[ch*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Window shift register advances on every accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_win <= '0;
    else if (accept) shift_win <= next_win;
  end

  // Output register: load on emit, drop valid when consumed with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_valid <= 1'b0;
      window_out   <= '0;
    end else if (emit) begin
      window_valid <= 1'b1;
      window_out   <= next_win;
    end else if (window_ready) begin
      window_valid <= 1'b0;
    end
  end

`ifdef MC_WINDOW_GEN_COUNT_EN
  localparam int CNT_W = $clog2((IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1)+1);

  // Window transfer counter, restarted on the frame_done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_count <= '0;
    else if (frame_done) win_count <= '0;
    else if (window_valid && window_ready) win_count <= win_count + CNT_W'(1);
  end
`endif

endmodule
